number_literal_decoder: RTL and testbench
=========================================

# number_literal_decoder

Reads a Verilog-style number literal one ASCII character per cycle and decodes it into a binary value, an x/z mask, the declared size and a sign flag. It is the reader side of the literal-formatting practice blocks: it parses what those blocks write (sized binary, all-x hex, negative decimal in two's complement, unsized hex). It sits behind a byte stream and produces one result per terminated literal.

## Interface
- WIDTH, 32: value/mask width; also the size reported for unsized literals.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- char_in  input  8  ASCII character.
- char_valid  input  1  char_in is presented this cycle.
- char_ready  output  1  decoder accepts char_in this cycle; a transfer occurs when char_valid && char_ready.
- value  output  WIDTH  decoded value, masked to size, two's complement if negative.
- xmask  output  WIDTH  1 per bit that is x or z.
- size  output  16  declared size; WIDTH when unsized.
- sized  output  1  literal carried an explicit size.
- neg  output  1  literal had a leading '-'.
- ovf  output  1  nonzero digit bits were discarded beyond size.
- done  output  1  one-cycle pulse: result outputs updated.
- error  output  1  one-cycle pulse: malformed literal discarded.

## Operation
- Terminators: ';', ' ', 0x0A. In IDLE, ' ' and 0x0A are ignored; ';' in IDLE raises error.
- States: IDLE, NUM, BASE, DIGITS, ERR, EMIT.
- IDLE: '-' sets neg and stays in IDLE (a second '-' goes to ERR); '0'-'9' starts the decimal accumulator and goes to NUM; '\'' goes to BASE unsized; anything else goes to ERR.
- NUM: decimal digits accumulate; '_' is ignored; '\'' latches the accumulator as the size and goes to BASE; a terminator goes to EMIT as an unsized decimal.
- Size rules: the size accumulator saturates at 0xFFFF. A size of 0 or a size greater than WIDTH goes to ERR.
- BASE: 'b', 'o', 'd', 'h' (case-insensitive) go to DIGITS; anything else goes to ERR.
- DIGITS: a digit valid for the base shifts into the accumulator (b: 1 bit, o: 3 bits, h: 4 bits, d: ×10 + digit). '_' is ignored. A terminator goes to EMIT if at least one digit was seen, else to ERR. Any other character goes to ERR.
- x/z digits ('x', 'X', 'z', 'Z', '?') shift all-ones into xmask and zeros into value for the digit's bit count. In base d, x/z goes to ERR.
- Extension: if the leftmost digit of a sized literal was x/z, the bits above the supplied digits up to size are set in xmask. Otherwise those bits are zero.
- EMIT: value = acc masked to size. If neg is set, value = (~acc + 1) masked to size. If neg is set and xmask is nonzero, xmask = all ones within size.
- ovf is set if any 1 bit or x bit was shifted above bit size-1, or above WIDTH-1 when unsized.
- ERR: consumes characters until a terminator, then pulses error and returns to IDLE. Result outputs are unchanged.
- Result outputs hold their values until the next EMIT.

## Timing
- Reset: state IDLE; value, xmask, size, sized, neg, ovf, done and error all 0; char_ready = 1.
- One character is accepted per cycle.
- The terminator is accepted in cycle n. In cycle n+1 the state is EMIT: done = 1, char_ready = 0, and the new results are visible. IDLE resumes in cycle n+2.
- error pulses in the cycle after the terminator is consumed in ERR; char_ready stays 1.
- Reset asserted mid-literal discards all partial state. Outputs return to reset values immediately (asynchronous reset).
- done and error are never asserted in the same cycle.

## Configuration
- NUMBER_LITERAL_DECODER_XZ_EN defined: x/z digits are accepted and xmask is populated as described above.
- Not defined: x/z characters are invalid and go to ERR. xmask is tied to 0. The extension logic is removed.

## Test plan
- "8'b0111_1011;" -> value 0x7B, size 8, sized 1, xmask 0, neg 0, ovf 0; done pulses the cycle after ';'.
- "16'hxxxx;" (XZ_EN defined) -> value 0, xmask 0xFFFF, size 16. Without the macro: error pulse, no done.
- "-4'd2;" -> value 0xE, size 4, neg 1, xmask 0.
- "'h1234;" -> value 0x1234, size 32, sized 0.
- "4'b1_0110;" -> value 0x6, ovf 1. "8'q1;" -> error pulse, outputs unchanged.
- Feed "8'b1", assert reset for one cycle, then feed "5;" -> all outputs are 0 during reset; then value 5, sized 0, size 32.

Source files
------------

// File: rtl/number_literal_decoder.sv
// number_literal_decoder: parses a Verilog-style number literal, one ASCII
// character per cycle, into value / x-z mask / size / sign / overflow.
// Optional feature macro: NUMBER_LITERAL_DECODER_XZ_EN. When it is defined,
// x/z digits are accepted and xmask is filled in. When it is undefined,
// x/z digits are malformed and xmask stays 0.
// Handshake: a character transfers when char_valid && char_ready.
// char_ready is low only in EMIT, the one-cycle result slot.
module number_literal_decoder #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       char_in,
  input  logic             char_valid,
  output logic             char_ready,
  output logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] xmask,
  output logic [15:0]      size,
  output logic             sized,
  output logic             neg,
  output logic             ovf,
  output logic             done,
  output logic             error,
  output logic [2:0]       state_dbg
);
  localparam int EW = WIDTH + 4;
  localparam logic [15:0] WIDTH16 = 16'(WIDTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_NUM    = 3'd1;
  localparam logic [2:0] S_BASE   = 3'd2;
  localparam logic [2:0] S_DIGITS = 3'd3;
  localparam logic [2:0] S_ERR    = 3'd4;
  localparam logic [2:0] S_EMIT   = 3'd5;

  localparam logic [1:0] B_BIN = 2'd0;
  localparam logic [1:0] B_OCT = 2'd1;
  localparam logic [1:0] B_DEC = 2'd2;
  localparam logic [1:0] B_HEX = 2'd3;

  // Returns a mask with the low n bits set; it saturates at all ones.
  function automatic logic [WIDTH-1:0] mask_low(input logic [15:0] n);
    logic [WIDTH:0] t;
    t = (WIDTH+1)'(1) << n;
    t = t - (WIDTH+1)'(1);
    return t[WIDTH-1:0];
  endfunction

  logic [2:0]       state_q, state_d;
  logic             neg_p_q, neg_p_d, sized_p_q, sized_p_d, seen_q, seen_d;
  logic             ovf_p_q, ovf_p_d;
  logic [15:0]      size_p_q, size_p_d, sacc_q, sacc_d;
  logic [1:0]       base_q, base_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] value_q, value_d, xmask_q, xmask_d;
  logic [15:0]      size_q, size_d;
  logic             sized_q, sized_d, neg_q, neg_d, ovf_q, ovf_d;
  logic             done_q, done_d, error_q, error_d;

  logic             take, is_term, is_dec, is_hex_letter, digit_ok, xz_ok, x_ovf;
  logic [3:0]       dval, dig_val;
  logic [2:0]       dig_bits;
  logic [7:0]       ch_lc;
  logic [19:0]      sacc_w;
  logic [15:0]      sacc_sat;
  logic [WIDTH-1:0] lim_mask, emit_val, emit_xm;
  logic [EW-1:0]    ext_mask, wide_dec, wide_v;

  assign take       = char_valid && char_ready;
  assign char_ready = (state_q != S_EMIT);
  assign state_dbg  = state_q;
  assign value = value_q;
  assign xmask = xmask_q;
  assign size  = size_q;
  assign sized = sized_q;
  assign neg   = neg_q;
  assign ovf   = ovf_q;
  assign done  = done_q;
  assign error = error_q;

  // Character classification and the arithmetic shared by the FSM.
  always_comb begin
    is_term       = (char_in == 8'h3B) || (char_in == 8'h20) || (char_in == 8'h0A);
    is_dec        = (char_in >= 8'h30) && (char_in <= 8'h39);
    ch_lc         = char_in | 8'h20;
    is_hex_letter = (ch_lc >= 8'h61) && (ch_lc <= 8'h66);
    dval          = char_in[3:0];
    dig_val       = is_hex_letter ? (char_in[3:0] + 4'd9) : char_in[3:0];
    digit_ok      = 1'b0;
    dig_bits      = 3'd4;
    case (base_q)
      B_BIN:   begin digit_ok = (char_in == 8'h30) || (char_in == 8'h31); dig_bits = 3'd1; end
      B_OCT:   begin digit_ok = (char_in >= 8'h30) && (char_in <= 8'h37); dig_bits = 3'd3; end
      B_HEX:   begin digit_ok = is_dec || is_hex_letter; dig_bits = 3'd4; end
      default: begin digit_ok = is_dec; dig_bits = 3'd4; end
    endcase
    lim_mask = mask_low(size_p_q);
    ext_mask = {4'b0, lim_mask};
    wide_dec = ({4'b0, acc_q} * EW'(10)) + EW'(dval);
    wide_v   = ({4'b0, acc_q} << dig_bits) | (digit_ok ? EW'(dig_val) : '0);
    sacc_w   = ({4'b0, sacc_q} * 20'd10) + {16'b0, dval};
    sacc_sat = (|sacc_w[19:16]) ? 16'hFFFF : sacc_w[15:0];
    emit_val = neg_p_q ? ((~acc_q + WIDTH'(1)) & lim_mask) : acc_q;
  end

`ifdef NUMBER_LITERAL_DECODER_XZ_EN
  logic [WIDTH-1:0] xacc_q, xacc_d, ext_bits;
  logic             first_xz_q, first_xz_d, is_xz;
  logic [15:0]      dbits_q, dbits_d;
  logic [3:0]       dig_ones;
  logic [EW-1:0]    wide_x;

  // x/z digit tracking, overflow of x bits and left extension of a leading x/z.
  always_comb begin
    is_xz    = (ch_lc == 8'h78) || (ch_lc == 8'h7A) || (char_in == 8'h3F);
    xz_ok    = is_xz;
    dig_ones = 4'hF >> (3'd4 - dig_bits);
    wide_x   = ({4'b0, xacc_q} << dig_bits) | (is_xz ? EW'(dig_ones) : '0);
    x_ovf    = |(wide_x & ~ext_mask);
    ext_bits = (sized_p_q && first_xz_q) ? (lim_mask & ~mask_low(dbits_q)) : '0;
    emit_xm  = xacc_q | ext_bits;
    if (neg_p_q && (emit_xm != '0)) emit_xm = lim_mask;
  end

  // x/z tracking registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xacc_q     <= '0;
      first_xz_q <= 1'b0;
      dbits_q    <= '0;
    end else begin
      xacc_q     <= xacc_d;
      first_xz_q <= first_xz_d;
      dbits_q    <= dbits_d;
    end
  end
`else
  assign xz_ok   = 1'b0;
  assign x_ovf   = 1'b0;
  assign emit_xm = '0;
`endif

  // Literal parsing FSM: the next state and the latched results.
  always_comb begin
    state_d = state_q;  neg_p_d = neg_p_q;  sized_p_d = sized_p_q;
    seen_d  = seen_q;   ovf_p_d = ovf_p_q;  size_p_d  = size_p_q;
    sacc_d  = sacc_q;   base_d  = base_q;   acc_d     = acc_q;
    value_d = value_q;  xmask_d = xmask_q;  size_d    = size_q;
    sized_d = sized_q;  neg_d   = neg_q;    ovf_d     = ovf_q;
    done_d  = 1'b0;     error_d = 1'b0;
`ifdef NUMBER_LITERAL_DECODER_XZ_EN
    xacc_d = xacc_q;  first_xz_d = first_xz_q;  dbits_d = dbits_q;
`endif
    case (state_q)
      S_IDLE: if (take) begin
        if (char_in == 8'h2D) begin
          if (neg_p_q) state_d = S_ERR;
          else         neg_p_d = 1'b1;
        end else if (is_term) begin
          if (char_in == 8'h3B) begin error_d = 1'b1; neg_p_d = 1'b0; end
        end else if (is_dec) begin
          state_d = S_NUM;  sacc_d = {12'b0, dval};  acc_d = WIDTH'(dval);
          size_p_d = WIDTH16;  sized_p_d = 1'b0;  ovf_p_d = 1'b0;
        end else if (char_in == 8'h27) begin
          state_d = S_BASE;  size_p_d = WIDTH16;  sized_p_d = 1'b0;
        end else begin
          state_d = S_ERR;
        end
      end
      S_NUM: if (take) begin
        if (is_dec) begin
          sacc_d = sacc_sat;
          acc_d  = wide_dec[WIDTH-1:0] & lim_mask;
          if (|(wide_dec & ~ext_mask)) ovf_p_d = 1'b1;
        end else if (char_in == 8'h5F) begin
          state_d = S_NUM;
        end else if (char_in == 8'h27) begin
          if ((sacc_q == 16'd0) || (sacc_q > WIDTH16)) state_d = S_ERR;
          else begin state_d = S_BASE; size_p_d = sacc_q; sized_p_d = 1'b1; end
        end else if (is_term) begin
          state_d = S_EMIT;  done_d = 1'b1;
          value_d = emit_val;  xmask_d = '0;  size_d = WIDTH16;
          sized_d = 1'b0;  neg_d = neg_p_q;  ovf_d = ovf_p_q;
        end else begin
          state_d = S_ERR;
        end
      end
      S_BASE: if (take) begin
        if ((ch_lc == 8'h62) || (ch_lc == 8'h6F) || (ch_lc == 8'h64) || (ch_lc == 8'h68)) begin
          state_d = S_DIGITS;  acc_d = '0;  ovf_p_d = 1'b0;  seen_d = 1'b0;
          base_d  = (ch_lc == 8'h62) ? B_BIN : (ch_lc == 8'h6F) ? B_OCT :
                    (ch_lc == 8'h64) ? B_DEC : B_HEX;
`ifdef NUMBER_LITERAL_DECODER_XZ_EN
          xacc_d = '0;  first_xz_d = 1'b0;  dbits_d = '0;
`endif
        end else if (is_term) begin
          state_d = S_IDLE;  error_d = 1'b1;  neg_p_d = 1'b0;
        end else begin
          state_d = S_ERR;
        end
      end
      S_DIGITS: if (take) begin
        if (char_in == 8'h5F) begin
          state_d = S_DIGITS;
        end else if (is_term) begin
          if (seen_q) begin
            state_d = S_EMIT;  done_d = 1'b1;
            value_d = emit_val;  xmask_d = emit_xm;  size_d = size_p_q;
            sized_d = sized_p_q;  neg_d = neg_p_q;  ovf_d = ovf_p_q;
          end else begin
            state_d = S_IDLE;  error_d = 1'b1;  neg_p_d = 1'b0;
          end
        end else if (base_q == B_DEC) begin
          if (is_dec) begin
            acc_d  = wide_dec[WIDTH-1:0] & lim_mask;  seen_d = 1'b1;
            if (|(wide_dec & ~ext_mask)) ovf_p_d = 1'b1;
          end else begin
            state_d = S_ERR;
          end
        end else if (digit_ok || xz_ok) begin
          acc_d  = wide_v[WIDTH-1:0] & lim_mask;  seen_d = 1'b1;
          if ((|(wide_v & ~ext_mask)) || x_ovf) ovf_p_d = 1'b1;
`ifdef NUMBER_LITERAL_DECODER_XZ_EN
          xacc_d = wide_x[WIDTH-1:0] & lim_mask;
          if (!seen_q) first_xz_d = is_xz;
          if (dbits_q < 16'hFF00) dbits_d = dbits_q + {13'b0, dig_bits};
`endif
        end else begin
          state_d = S_ERR;
        end
      end
      S_ERR: if (take && is_term) begin
        state_d = S_IDLE;  error_d = 1'b1;  neg_p_d = 1'b0;
      end
      S_EMIT: begin
        state_d = S_IDLE;  neg_p_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;  neg_p_q <= 1'b0;  sized_p_q <= 1'b0;  seen_q <= 1'b0;
      ovf_p_q <= 1'b0;    size_p_q <= WIDTH16;  sacc_q <= '0;  base_q <= B_BIN;
      acc_q   <= '0;      value_q <= '0;  xmask_q <= '0;  size_q <= '0;
      sized_q <= 1'b0;    neg_q <= 1'b0;  ovf_q <= 1'b0;  done_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;  neg_p_q <= neg_p_d;  sized_p_q <= sized_p_d;  seen_q <= seen_d;
      ovf_p_q <= ovf_p_d;  size_p_q <= size_p_d;  sacc_q <= sacc_d;  base_q <= base_d;
      acc_q   <= acc_d;    value_q <= value_d;  xmask_q <= xmask_d;  size_q <= size_d;
      sized_q <= sized_d;  neg_q <= neg_d;  ovf_q <= ovf_d;  done_q <= done_d;
      error_q <= error_d;
    end
  end
endmodule

// File: tb/tb_number_literal_decoder.sv
// Directed testbench for number_literal_decoder.
module tb_number_literal_decoder;
  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  char_in;
  logic        char_valid;
  logic        char_ready;
  logic [31:0] value, xmask;
  logic [15:0] size;
  logic        sized, neg, ovf, done, error;
  logic [2:0]  state_dbg;

  int total = 0;
  int bad   = 0;

  number_literal_decoder #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .char_in(char_in), .char_valid(char_valid),
    .char_ready(char_ready), .value(value), .xmask(xmask), .size(size),
    .sized(sized), .neg(neg), .ovf(ovf), .done(done), .error(error),
    .state_dbg(state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver: present one character for one clock edge.
  task automatic send_char(input logic [7:0] c);
    @(negedge clk);
    char_valid = 1'b1;
    char_in    = c;
    @(posedge clk);
    #1;
    char_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
  endtask

  // Called just after the terminator edge: checks the done cycle, then the one after.
  task automatic expect_done(input string tag, input logic [31:0] v, input logic [31:0] xm,
                             input logic [15:0] sz, input logic szd, input logic ng,
                             input logic ov);
    chk({tag, ".done"},  {63'b0, done}, 64'd1);
    chk({tag, ".error"}, {63'b0, error}, 64'd0);
    chk({tag, ".ready"}, {63'b0, char_ready}, 64'd0);
    chk({tag, ".state"}, {61'b0, state_dbg}, 64'd5);
    chk({tag, ".value"}, {32'b0, value}, {32'b0, v});
    chk({tag, ".xmask"}, {32'b0, xmask}, {32'b0, xm});
    chk({tag, ".size"},  {48'b0, size}, {48'b0, sz});
    chk({tag, ".sized"}, {63'b0, sized}, {63'b0, szd});
    chk({tag, ".neg"},   {63'b0, neg}, {63'b0, ng});
    chk({tag, ".ovf"},   {63'b0, ovf}, {63'b0, ov});
    @(posedge clk);
    #1;
    chk({tag, ".done_drop"}, {63'b0, done}, 64'd0);
    chk({tag, ".ready_back"}, {63'b0, char_ready}, 64'd1);
    chk({tag, ".value_hold"}, {32'b0, value}, {32'b0, v});
  endtask

  task automatic expect_error(input string tag, input logic [31:0] v);
    chk({tag, ".error"}, {63'b0, error}, 64'd1);
    chk({tag, ".done"},  {63'b0, done}, 64'd0);
    chk({tag, ".ready"}, {63'b0, char_ready}, 64'd1);
    chk({tag, ".value_kept"}, {32'b0, value}, {32'b0, v});
    @(posedge clk);
    #1;
    chk({tag, ".error_drop"}, {63'b0, error}, 64'd0);
  endtask

  initial begin
    // Reset
    reset      = 1'b1;
    char_valid = 1'b0;
    char_in    = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.value", {32'b0, value}, 64'd0);
    chk("rst.size",  {48'b0, size}, 64'd0);
    chk("rst.flags", {58'b0, sized, neg, ovf, done, error, char_ready}, 64'd1);
    chk("rst.state", {61'b0, state_dbg}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    send_str("8'b0111_1011;");
    expect_done("bin8", 32'h7B, 32'h0, 16'd8, 1'b1, 1'b0, 1'b0);

`ifdef NUMBER_LITERAL_DECODER_XZ_EN
    send_str("16'hxxxx;");
    expect_done("allx", 32'h0, 32'hFFFF, 16'd16, 1'b1, 1'b0, 1'b0);
    send_str("8'bx1;");
    expect_done("xext", 32'h01, 32'hFE, 16'd8, 1'b1, 1'b0, 1'b0);
`else
    send_str("16'hxxxx;");
    expect_error("allx_off", 32'h7B);
`endif

    send_str("-4'd2;");
    expect_done("negdec", 32'hE, 32'h0, 16'd4, 1'b1, 1'b1, 1'b0);

    send_str("'h1234;");
    expect_done("unsz_hex", 32'h1234, 32'h0, 16'd32, 1'b0, 1'b0, 1'b0);

    send_str("4'b1_0110;");
    expect_done("ovf", 32'h6, 32'h0, 16'd4, 1'b1, 1'b0, 1'b1);

    send_str("8'q1;");
    expect_error("badbase", 32'h6);
    chk("badbase.ovf_kept", {63'b0, ovf}, 64'd1);
    chk("badbase.size_kept", {48'b0, size}, 64'd4);

    send_str("123;");
    expect_done("dec_unsz", 32'd123, 32'h0, 16'd32, 1'b0, 1'b0, 1'b0);

    send_str(";");
    expect_error("idle_semi", 32'd123);

    send_str("0'b1;");
    expect_error("size0", 32'd123);

    send_str("33'h1;");
    expect_error("size33", 32'd123);

    send_str("8'h;");
    expect_error("nodigits", 32'd123);

    send_str("-8'h1;");
    expect_done("neg_hex", 32'hFF, 32'h0, 16'd8, 1'b1, 1'b1, 1'b0);

    // Reset in the middle of a literal
    send_str("8'b1");
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst.value", {32'b0, value}, 64'd0);
    chk("midrst.size",  {48'b0, size}, 64'd0);
    chk("midrst.flags", {58'b0, sized, neg, ovf, done, error, char_ready}, 64'd1);
    chk("midrst.state", {61'b0, state_dbg}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    send_str("5;");
    expect_done("after_rst", 32'd5, 32'h0, 16'd32, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
